mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 50 +++++
 rtl/mem_port_arbiter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: the instruction-fetch port, the MEM-stage port and the
// single shared RAM port.
//
// Modports:
//   slave  - the arbiter. It receives requests and RAM responses and drives dones, read data
//            and the RAM strobe.
//   master - the environment. This is the pipeline plus the RAM model.
//
// Signals:
//   if_req, if_addr[15:0]           fetch request and address (held until if_done)
//   if_done, if_rdata[15:0]         fetch completion pulse and fetched word
//   mem_read, mem_write             MEM-stage requests (held until mem_done)
//   mem_addr[15:0], mem_wdata[15:0] data address and store data
//   mem_done, mem_rdata[15:0]       MEM completion pulse and load data
//   ram_req, ram_we                 RAM strobe and write enable
//   ram_addr[15:0], ram_wdata[15:0] RAM address and write data
//   ram_rdata[15:0], ram_ack        RAM read data and one-cycle completion
//   busy, timeout_err               arbiter status
interface mem_port_arbiter_if;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_done;
    logic [15:0] if_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_done;
    logic [15:0] mem_rdata;
    logic        ram_req;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        ram_ack;
    logic        busy;
    logic        timeout_err;

    modport slave (
        input  if_req, if_addr, mem_read, mem_write, mem_addr, mem_wdata, ram_rdata, ram_ack,
        output if_done, if_rdata, mem_done, mem_rdata, ram_req, ram_we, ram_addr, ram_wdata,
               busy, timeout_err
    );

    modport master (
        output if_req, if_addr, mem_read, mem_write, mem_addr, mem_wdata, ram_rdata, ram_ack,
        input  if_done, if_rdata, mem_done, mem_rdata, ram_req, ram_we, ram_addr, ram_wdata,
               busy, timeout_err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between instruction fetch (IF) and the MEM stage.
//
// Arbitration rules:
//   - MEM normally wins over IF.
//   - IF is forced to win once STARVE_LIMIT consecutive MEM grants were made while IF waited.
//   - Every output is registered.
//   - The cycle that carries a done pulse never grants, so accesses are separated by at least
//     one idle cycle.
//
// Ports:
//   clk  - clock
//   rst  - asynchronous, active-high reset. It clears all state and outputs.
//   bus  - mem_port_arbiter_if.slave. It carries the IF, MEM and RAM handshakes and the status.
//
// Parameters:
//   STARVE_LIMIT - MEM grants tolerated while IF waits (1..15)
//   TIMEOUT      - cycles to wait for ram_ack before aborting
//
// Optional feature, enabled by defining the macro MEM_ARB_TIMEOUT_EN:
//   - An access with no ram_ack for TIMEOUT cycles is aborted.
//   - The abort completes the access with read data 16'hFFFF and sets the sticky timeout_err.
//   - Without the macro, the arbiter waits for ram_ack forever and timeout_err is tied to 0.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 16
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || TIMEOUT < 1) begin : gBadParams
        $error("mem_port_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {StIdle, StMemAcc, StIfAcc} stateE;

    localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

    stateE       stateQ, stateD;
    logic [3:0]  starveQ, starveD;
    logic        ramReqQ, ramReqD;
    logic        ramWeQ, ramWeD;
    logic [15:0] ramAddrQ, ramAddrD;
    logic [15:0] ramWdataQ, ramWdataD;
    logic        ifDoneQ, ifDoneD;
    logic [15:0] ifRdataQ, ifRdataD;
    logic        memDoneQ, memDoneD;
    logic [15:0] memRdataQ, memRdataD;
    logic        busyQ, busyD;
    logic        memReq, forceIf;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TimerW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TimerW-1:0] timerQ, timerD;
    logic              timeoutErrQ, timeoutErrD;
`endif

    always_comb begin
        stateD    = stateQ;
        starveD   = starveQ;
        ramReqD   = ramReqQ;
        ramWeD    = ramWeQ;
        ramAddrD  = ramAddrQ;
        ramWdataD = ramWdataQ;
        ifDoneD   = 1'b0;
        ifRdataD  = ifRdataQ;
        memDoneD  = 1'b0;
        memRdataD = memRdataQ;
`ifdef MEM_ARB_TIMEOUT_EN
        timerD      = '0;
        timeoutErrD = timeoutErrQ;
`endif
        memReq  = bus.mem_read | bus.mem_write;
        forceIf = bus.if_req && (starveQ == StarveMax);

        unique case (stateQ)
            StIdle: begin
                // Requesters still hold their request during the done cycle, so that cycle
                // must not grant.
                if (!ifDoneQ && !memDoneQ) begin
                    if (memReq && !forceIf) begin
                        stateD    = StMemAcc;
                        ramReqD   = 1'b1;
                        ramWeD    = bus.mem_write;
                        ramAddrD  = bus.mem_addr;
                        ramWdataD = bus.mem_wdata;
                        if (bus.if_req && (starveQ != StarveMax)) begin
                            starveD = starveQ + 4'd1;
                        end
                    end else if (bus.if_req) begin
                        stateD    = StIfAcc;
                        ramReqD   = 1'b1;
                        ramWeD    = 1'b0;
                        ramAddrD  = bus.if_addr;
                        ramWdataD = 16'h0000;
                        starveD   = 4'd0;
                    end
                end
            end
            StMemAcc, StIfAcc: begin
                if (bus.ram_ack) begin
                    stateD  = StIdle;
                    ramReqD = 1'b0;
                    if (stateQ == StMemAcc) begin
                        memDoneD = 1'b1;
                        if (!ramWeQ) begin
                            memRdataD = bus.ram_rdata;
                        end
                    end else begin
                        ifDoneD  = 1'b1;
                        ifRdataD = bus.ram_rdata;
                    end
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (timerQ == TimerW'(TIMEOUT - 1)) begin
                    stateD      = StIdle;
                    ramReqD     = 1'b0;
                    timeoutErrD = 1'b1;
                    if (stateQ == StMemAcc) begin
                        memDoneD  = 1'b1;
                        memRdataD = 16'hFFFF;
                    end else begin
                        ifDoneD  = 1'b1;
                        ifRdataD = 16'hFFFF;
                    end
                end else begin
                    timerD = timerQ + 1'b1;
                end
`endif
            end
            default: stateD = StIdle;
        endcase

        busyD = (stateD != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ    <= StIdle;
            starveQ   <= 4'd0;
            ramReqQ   <= 1'b0;
            ramWeQ    <= 1'b0;
            ramAddrQ  <= 16'h0000;
            ramWdataQ <= 16'h0000;
            ifDoneQ   <= 1'b0;
            ifRdataQ  <= 16'h0000;
            memDoneQ  <= 1'b0;
            memRdataQ <= 16'h0000;
            busyQ     <= 1'b0;
        end else begin
            stateQ    <= stateD;
            starveQ   <= starveD;
            ramReqQ   <= ramReqD;
            ramWeQ    <= ramWeD;
            ramAddrQ  <= ramAddrD;
            ramWdataQ <= ramWdataD;
            ifDoneQ   <= ifDoneD;
            ifRdataQ  <= ifRdataD;
            memDoneQ  <= memDoneD;
            memRdataQ <= memRdataD;
            busyQ     <= busyD;
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timerQ      <= '0;
            timeoutErrQ <= 1'b0;
        end else begin
            timerQ      <= timerD;
            timeoutErrQ <= timeoutErrD;
        end
    end

    assign bus.timeout_err = timeoutErrQ;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.ram_req   = ramReqQ;
    assign bus.ram_we    = ramWeQ;
    assign bus.ram_addr  = ramAddrQ;
    assign bus.ram_wdata = ramWdataQ;
    assign bus.if_done   = ifDoneQ;
    assign bus.if_rdata  = ifRdataQ;
    assign bus.mem_done  = memDoneQ;
    assign bus.mem_rdata = memRdataQ;
    assign bus.busy      = busyQ;
endmodule
